// File: rtl/frame_generator_mb.sv
// Multi-lane AXI-Stream Ethernet test-frame source programmed over an 8-bit Avalon-MM slave.
// Frames are preamble/SFD, header and payload (from a buffer or a counting pattern), with a gap between frames.
module frame_generator_mb #(
  parameter int DATA_BYTES    = 2,
  parameter int PAYLOAD_DEPTH = 256,
  parameter int FCOUNT_W      = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [7:0]              writedata,
  input  logic                    write,
  input  logic                    chipselect,
  input  logic [7:0]              address,
  input  logic                    read,
  output logic [7:0]              readdata,
  output logic [8*DATA_BYTES-1:0] egress_port_tdata,
  output logic [DATA_BYTES-1:0]   egress_port_tkeep,
  output logic                    egress_port_tlast,
  output logic                    egress_port_tvalid,
  input  logic                    egress_port_tready
);

  localparam int PA_W = $clog2(PAYLOAD_DEPTH);
  localparam int DW   = 8 * DATA_BYTES;
  localparam logic [15:0]         DB16     = 16'(DATA_BYTES);
  localparam logic [15:0]         DEPTH16  = 16'(PAYLOAD_DEPTH);
  localparam logic [PA_W:0]       PTR_FULL = (PA_W+1)'(PAYLOAD_DEPTH);
  localparam logic [PA_W:0]       PTR_ONE  = (PA_W+1)'(1);
  localparam logic [FCOUNT_W-1:0] FS_ONE   = FCOUNT_W'(1);

  typedef enum logic [1:0] {ST_IDLE, ST_SEND, ST_GAP} state_t;
  state_t state, state_nxt;

  logic [7:0]          regs [20];
  logic [7:0]          pbuf [PAYLOAD_DEPTH];
  logic [PA_W:0]       wr_ptr;
  logic                wr_err, buf_full, busy;
  logic                wr_en, rd_en, ctrl_wr, data_wr, en_rise;
  logic [15:0]         fcount16, fs16;
  logic [FCOUNT_W-1:0] fcount, frames_sent;
  logic                start_ok, hs, last_beat, load_snap;
  logic [7:0]          snap_hdr [16];
  logic [15:0]         snap_len, snap_le, total, byte_idx;
  logic                snap_pat;
  logic [7:0]          snap_fs, gap_cnt;
  logic [31:0]         checksum, csum_acc, beat_sum;
  logic [15:0]         lane_k [DATA_BYTES];
  logic [7:0]          lane_byte [DATA_BYTES];
  logic [DATA_BYTES-1:0] lane_vld;

  assign wr_en    = chipselect && write;
  assign rd_en    = chipselect && read;
  assign ctrl_wr  = wr_en && (address == 8'd19);
  assign data_wr  = wr_en && (address == 8'd32);
  assign en_rise  = ctrl_wr && writedata[0] && !regs[19][0];
  assign buf_full = (wr_ptr == PTR_FULL);
  assign busy     = (state != ST_IDLE);
  assign fcount16 = {regs[18], regs[17]};
  assign fcount   = fcount16[FCOUNT_W-1:0];
  assign fs16     = 16'(frames_sent);
  assign start_ok = regs[19][0] && ((fcount == '0) || (frames_sent < fcount));
  assign hs       = (state == ST_SEND) && egress_port_tready;
  assign snap_le  = (snap_len > DEPTH16) ? DEPTH16 : snap_len;
  assign total    = 16'd24 + snap_le;
  assign last_beat = (byte_idx + DB16) >= total;
  assign load_snap = (state_nxt == ST_SEND) && (state != ST_SEND);

  // CTRL bit2 is an action, so it is never stored; bit3 is stored but only acts on the write
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 20; i++) regs[i] <= 8'h00;
      wr_ptr <= '0;
      wr_err <= 1'b0;
    end else if (wr_en) begin
      if (address < 8'd19) regs[address[4:0]] <= writedata;
      if (ctrl_wr) begin
        regs[19] <= writedata & 8'hFB;
        if (writedata[2]) wr_ptr <= '0;
        if (writedata[3]) wr_err <= 1'b0;
      end
      if (data_wr) begin
        if (busy) wr_err <= 1'b1;
        else if (!buf_full) wr_ptr <= wr_ptr + PTR_ONE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && data_wr && !busy && !buf_full) pbuf[wr_ptr[PA_W-1:0]] <= writedata;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      readdata <= 8'h00;
    end else if (rd_en) begin
      case (address)
        8'd20:   readdata <= {5'b0, wr_err, buf_full, busy};
        8'd21:   readdata <= checksum[7:0];
        8'd22:   readdata <= checksum[15:8];
        8'd23:   readdata <= checksum[23:16];
        8'd24:   readdata <= checksum[31:24];
        8'd25:   readdata <= fs16[7:0];
        8'd26:   readdata <= fs16[15:8];
        default: readdata <= (address < 8'd20) ? regs[address[4:0]] : 8'h00;
      endcase
    end else begin
      readdata <= 8'h00;
    end
  end

  // A gap of IFG cycles ends straight into the next frame so IFG>0 gives exactly IFG idle beats
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (start_ok) state_nxt = ST_SEND;
      ST_SEND: if (hs && last_beat) state_nxt = (regs[16] != 8'd0) ? ST_GAP : ST_IDLE;
      ST_GAP:  if (gap_cnt == 8'd0) state_nxt = start_ok ? ST_SEND : ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    beat_sum = 32'd0;
    for (int j = 0; j < DATA_BYTES; j++) begin
      lane_k[j]    = byte_idx + 16'(j);
      lane_vld[j]  = lane_k[j] < total;
      lane_byte[j] = 8'h00;
      if (lane_vld[j]) begin
        if (lane_k[j] < 16'd7)       lane_byte[j] = 8'hAA;
        else if (lane_k[j] == 16'd7) lane_byte[j] = 8'hAB;
        else if (lane_k[j] < 16'd24) lane_byte[j] = snap_hdr[4'(lane_k[j] - 16'd8)];
        else begin
          lane_byte[j] = snap_pat ? (lane_k[j][7:0] - 8'd24 + snap_fs)
                                  : pbuf[PA_W'(lane_k[j] - 16'd24)];
          beat_sum = beat_sum + {24'h0, lane_byte[j]};
        end
      end
    end
  end

  always_comb begin
    egress_port_tdata = '0;
    egress_port_tkeep = '0;
    for (int j = 0; j < DATA_BYTES; j++) begin
      if (state == ST_SEND) begin
        egress_port_tdata[DW-1-8*j -: 8]   = lane_byte[j];
        egress_port_tkeep[DATA_BYTES-1-j] = lane_vld[j];
      end
    end
  end

  assign egress_port_tvalid = (state == ST_SEND);
  assign egress_port_tlast  = (state == ST_SEND) && last_beat;

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_IDLE;
      byte_idx    <= '0;
      gap_cnt     <= '0;
      snap_len    <= '0;
      snap_pat    <= 1'b0;
      snap_fs     <= '0;
      for (int i = 0; i < 16; i++) snap_hdr[i] <= 8'h00;
      csum_acc    <= '0;
      frames_sent <= '0;
      checksum    <= '0;
    end else begin
      state <= state_nxt;
      // header snapshot is stored in wire order: length goes out high byte first
      if (load_snap) begin
        byte_idx <= '0;
        csum_acc <= '0;
        for (int i = 0; i < 12; i++) snap_hdr[i] <= regs[i];
        snap_hdr[12] <= regs[13];
        snap_hdr[13] <= regs[12];
        snap_hdr[14] <= regs[14];
        snap_hdr[15] <= regs[15];
        snap_len <= {regs[13], regs[12]};
        snap_pat <= regs[19][1];
        snap_fs  <= frames_sent[7:0];
      end else if (hs) begin
        byte_idx <= byte_idx + DB16;
        csum_acc <= csum_acc + beat_sum;
      end
      if (hs && last_beat) gap_cnt <= regs[16] - 8'd1;
      else if ((state == ST_GAP) && (gap_cnt != 8'd0)) gap_cnt <= gap_cnt - 8'd1;
      if (en_rise) begin
        frames_sent <= '0;
        checksum    <= '0;
      end else if (hs && last_beat) begin
        frames_sent <= frames_sent + FS_ONE;
        checksum    <= csum_acc + beat_sum;
      end
    end
  end

endmodule

// File: tb/tb_frame_generator_mb.sv
// Directed bench for frame_generator_mb with DATA_BYTES=2, PAYLOAD_DEPTH=256.
// Expected beats come from a byte-level frame model built from the fields the bench programs.
module tb_frame_generator_mb;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  writedata = 8'h00, address = 8'h00;
  logic        write = 1'b0, chipselect = 1'b0, read = 1'b0;
  logic [7:0]  readdata;
  logic [15:0] tdata;
  logic [1:0]  tkeep;
  logic        tlast, tvalid;
  logic        tready = 1'b1;

  int errors = 0, checks = 0, cyc = 0, n_last = 0, stall_cnt = 0;
  logic [15:0] cap_data[$];
  logic [1:0]  cap_keep[$];
  logic        cap_last[$];
  int          cap_cyc[$];
  logic [15:0] exp_data[$];
  logic [1:0]  exp_keep[$];
  logic        exp_last[$];
  logic [7:0]  tb_buf[256];
  logic [7:0]  tb_dst[6] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
  logic [7:0]  tb_src[6] = '{8'h77, 8'h88, 8'h99, 8'hAA, 8'hBB, 8'hCC};
  logic [7:0]  tb_type[2] = '{8'h88, 8'hB5};
  logic        stalled = 1'b0;
  logic [18:0] held;
  logic [7:0]  rv;

  frame_generator_mb #(.DATA_BYTES(2), .PAYLOAD_DEPTH(256), .FCOUNT_W(16)) dut (
    .clk(clk), .reset(reset), .writedata(writedata), .write(write),
    .chipselect(chipselect), .address(address), .read(read), .readdata(readdata),
    .egress_port_tdata(tdata), .egress_port_tkeep(tkeep), .egress_port_tlast(tlast),
    .egress_port_tvalid(tvalid), .egress_port_tready(tready));

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // sink monitor: records handshaken beats and checks beats held while stalled
  always @(negedge clk) begin
    if (!reset && tvalid) begin
      if (stalled) begin
        checks++;
        if ({tdata, tkeep, tlast} !== held) begin
          errors++;
          $display("FAIL stall_hold: got %h required %h", {tdata, tkeep, tlast}, held);
        end
      end
      if (tready) begin
        cap_data.push_back(tdata); cap_keep.push_back(tkeep);
        cap_last.push_back(tlast); cap_cyc.push_back(cyc);
        if (tlast) n_last++;
      end else stall_cnt++;
      stalled = !tready;
      held = {tdata, tkeep, tlast};
    end else stalled = 1'b0;
  end

  task automatic wr(input logic [7:0] a, input logic [7:0] d);
    @(negedge clk);
    address = a; writedata = d; chipselect = 1'b1; write = 1'b1;
    @(negedge clk);
    chipselect = 1'b0; write = 1'b0;
  endtask

  task automatic rd(input logic [7:0] a, output logic [7:0] d);
    @(negedge clk);
    address = a; chipselect = 1'b1; read = 1'b1;
    @(posedge clk); #1;
    d = readdata;
    chipselect = 1'b0; read = 1'b0;
  endtask

  task automatic clear_cap();
    cap_data.delete(); cap_keep.delete(); cap_last.delete(); cap_cyc.delete();
    n_last = 0;
  endtask

  task automatic wait_lasts(input int n, input int budget, input bit stall, input string name);
    int c = 0;
    while (n_last < n && c < budget) begin
      @(posedge clk); #1;
      if (stall) tready = 1'($urandom_range(0, 1));
      c++;
    end
    tready = 1'b1;
    checks++;
    if (n_last < n) begin
      errors++;
      $display("FAIL %s_timeout: frames seen %0d required %0d", name, n_last, n);
    end
  endtask

  task automatic build_exp(input int len, input bit pat, input int f);
    logic [7:0] b[$];
    int le;
    exp_data.delete(); exp_keep.delete(); exp_last.delete();
    for (int i = 0; i < 7; i++) b.push_back(8'hAA);
    b.push_back(8'hAB);
    for (int i = 0; i < 6; i++) b.push_back(tb_dst[i]);
    for (int i = 0; i < 6; i++) b.push_back(tb_src[i]);
    b.push_back(8'(len >> 8)); b.push_back(8'(len));
    b.push_back(tb_type[0]); b.push_back(tb_type[1]);
    le = (len > 256) ? 256 : len;
    for (int i = 0; i < le; i++) b.push_back(pat ? 8'(i + f) : tb_buf[i]);
    for (int s = 0; s < b.size(); s += 2) begin
      if (s + 1 < b.size()) begin
        exp_data.push_back({b[s], b[s+1]}); exp_keep.push_back(2'b11);
      end else begin
        exp_data.push_back({b[s], 8'h00}); exp_keep.push_back(2'b10);
      end
      exp_last.push_back(s + 2 >= b.size());
    end
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    @(negedge clk); reset = 1'b0;
    checks++;
    if ({tvalid, tlast, tkeep, tdata} !== 20'h0) begin
      errors++; $display("FAIL reset_outputs: got %h required 0", {tvalid, tlast, tkeep, tdata});
    end
    rd(8'd20, rv); checks++;
    if (rv !== 8'h00) begin errors++; $display("FAIL reset_status: got %h required 00", rv); end
    rd(8'd19, rv); checks++;
    if (rv !== 8'h00) begin errors++; $display("FAIL reset_ctrl: got %h required 00", rv); end
  endtask

  task automatic test_regs();
    for (int i = 0; i < 6; i++) begin wr(8'(i), tb_dst[i]); wr(8'(6 + i), tb_src[i]); end
    wr(8'd14, tb_type[0]); wr(8'd15, tb_type[1]); wr(8'd16, 8'd0);
    rd(8'd3, rv); checks++;
    if (rv !== 8'h44) begin errors++; $display("FAIL readback_dst3: got %h required 44", rv); end
    rd(8'd15, rv); checks++;
    if (rv !== 8'hB5) begin errors++; $display("FAIL readback_type1: got %h required B5", rv); end
    @(posedge clk); #1; checks++;
    if (readdata !== 8'h00) begin errors++; $display("FAIL readdata_idle: got %h required 00", readdata); end
    wr(8'd19, 8'h06);
    rd(8'd19, rv); checks++;
    if (rv !== 8'h02) begin errors++; $display("FAIL ctrl_selfclear: got %h required 02", rv); end
    rd(8'd40, rv); checks++;
    if (rv !== 8'h00) begin errors++; $display("FAIL unmapped_read: got %h required 00", rv); end
    wr(8'd19, 8'h00);
  endtask

  task automatic test_basic_frame();
    wr(8'd19, 8'h04);
    for (int i = 0; i < 4; i++) begin wr(8'd32, 8'(i + 1)); tb_buf[i] = 8'(i + 1); end
    wr(8'd12, 8'd4); wr(8'd13, 8'd0); wr(8'd17, 8'd1); wr(8'd18, 8'd0);
    clear_cap();
    wr(8'd19, 8'h01);
    wait_lasts(1, 200, 1'b0, "basic");
    build_exp(4, 1'b0, 0);
    checks++;
    if (cap_data.size() != 14) begin errors++; $display("FAIL basic_beats: got %0d required 14", cap_data.size()); end
    for (int i = 0; i < 14 && i < cap_data.size(); i++) begin
      checks++;
      if ({cap_data[i], cap_keep[i], cap_last[i]} !== {exp_data[i], exp_keep[i], exp_last[i]}) begin
        errors++;
        $display("FAIL basic_beat%0d: got %h/%b/%b required %h/%b/%b", i, cap_data[i], cap_keep[i],
                 cap_last[i], exp_data[i], exp_keep[i], exp_last[i]);
      end
    end
    rd(8'd21, rv); checks++;
    if (rv !== 8'h0A) begin errors++; $display("FAIL basic_checksum: got %h required 0A", rv); end
    rd(8'd25, rv); checks++;
    if (rv !== 8'h01) begin errors++; $display("FAIL basic_frames_sent: got %h required 01", rv); end
    rd(8'd20, rv); checks++;
    if (rv !== 8'h00) begin errors++; $display("FAIL basic_status_idle: got %h required 00", rv); end
  endtask

  task automatic test_odd_length();
    wr(8'd19, 8'h00);
    wr(8'd32, 8'h05); tb_buf[4] = 8'h05;
    wr(8'd12, 8'd5);
    clear_cap();
    wr(8'd19, 8'h01);
    wait_lasts(1, 200, 1'b0, "odd");
    build_exp(5, 1'b0, 0);
    checks++;
    if (cap_data.size() != 15) begin errors++; $display("FAIL odd_beats: got %0d required 15", cap_data.size()); end
    for (int i = 0; i < 15 && i < cap_data.size(); i++) begin
      checks++;
      if ({cap_data[i], cap_keep[i], cap_last[i]} !== {exp_data[i], exp_keep[i], exp_last[i]}) begin
        errors++;
        $display("FAIL odd_beat%0d: got %h/%b/%b required %h/%b/%b", i, cap_data[i], cap_keep[i],
                 cap_last[i], exp_data[i], exp_keep[i], exp_last[i]);
      end
    end
    if (cap_data.size() == 15) begin
      checks++;
      if ({cap_data[14], cap_keep[14]} !== {16'h0500, 2'b10}) begin
        errors++; $display("FAIL odd_last_partial: got %h/%b required 0500/10", cap_data[14], cap_keep[14]);
      end
    end
    rd(8'd21, rv); checks++;
    if (rv !== 8'h0F) begin errors++; $display("FAIL odd_checksum: got %h required 0F", rv); end
  endtask

  task automatic test_backpressure();
    wr(8'd19, 8'h00);
    clear_cap();
    stall_cnt = 0;
    wr(8'd19, 8'h01);
    wait_lasts(1, 2000, 1'b1, "bp");
    build_exp(5, 1'b0, 0);
    checks++;
    if (cap_data.size() != 15) begin errors++; $display("FAIL bp_beats: got %0d required 15", cap_data.size()); end
    for (int i = 0; i < 15 && i < cap_data.size(); i++) begin
      checks++;
      if ({cap_data[i], cap_keep[i], cap_last[i]} !== {exp_data[i], exp_keep[i], exp_last[i]}) begin
        errors++;
        $display("FAIL bp_beat%0d: got %h/%b/%b required %h/%b/%b", i, cap_data[i], cap_keep[i],
                 cap_last[i], exp_data[i], exp_keep[i], exp_last[i]);
      end
    end
    checks++;
    if (stall_cnt == 0) begin errors++; $display("FAIL bp_stalls: got 0 stalled cycles required >0"); end
  endtask

  task automatic test_pattern_gap();
    wr(8'd19, 8'h00);
    wr(8'd12, 8'd4); wr(8'd16, 8'd5); wr(8'd17, 8'd3);
    clear_cap();
    wr(8'd19, 8'h03);
    wait_lasts(3, 400, 1'b0, "pattern");
    checks++;
    if (cap_data.size() != 42) begin errors++; $display("FAIL pat_beats: got %0d required 42", cap_data.size()); end
    for (int f = 0; f < 3; f++) begin
      build_exp(4, 1'b1, f);
      for (int i = 0; i < 14 && 14*f + i < cap_data.size(); i++) begin
        checks++;
        if ({cap_data[14*f+i], cap_keep[14*f+i], cap_last[14*f+i]} !== {exp_data[i], exp_keep[i], exp_last[i]}) begin
          errors++;
          $display("FAIL pat_f%0d_beat%0d: got %h required %h", f, i, cap_data[14*f+i], exp_data[i]);
        end
      end
    end
    for (int f = 1; f < 3 && 14*f < cap_cyc.size(); f++) begin
      checks++;
      if (cap_cyc[14*f] - cap_cyc[14*f-1] != 6) begin
        errors++;
        $display("FAIL pat_gap%0d: got %0d idle cycles required 5", f, cap_cyc[14*f] - cap_cyc[14*f-1] - 1);
      end
    end
    repeat (30) @(posedge clk);
    checks++;
    if (cap_data.size() != 42) begin errors++; $display("FAIL pat_stop: got %0d beats required 42", cap_data.size()); end
    rd(8'd25, rv); checks++;
    if (rv !== 8'h03) begin errors++; $display("FAIL pat_frames_sent: got %h required 03", rv); end
    rd(8'd21, rv); checks++;
    if (rv !== 8'h0E) begin errors++; $display("FAIL pat_checksum: got %h required 0E", rv); end
    rd(8'd20, rv); checks++;
    if (rv !== 8'h00) begin errors++; $display("FAIL pat_idle: got %h required 00", rv); end
  endtask

  task automatic test_clamp_full();
    int c = 0;
    wr(8'd19, 8'h00); wr(8'd19, 8'h04);
    for (int i = 0; i < 256; i++) begin wr(8'd32, 8'(i)); tb_buf[i] = 8'(i); end
    rd(8'd20, rv); checks++;
    if (rv !== 8'h02) begin errors++; $display("FAIL full_flag: got %h required 02", rv); end
    wr(8'd32, 8'hEE);
    wr(8'd12, 8'h2C); wr(8'd13, 8'h01); wr(8'd16, 8'd0); wr(8'd17, 8'd1);
    clear_cap();
    wr(8'd19, 8'h01);
    while (cap_data.size() < 20 && c < 200) begin @(posedge clk); c++; end
    wr(8'd32, 8'h55);
    rd(8'd20, rv); checks++;
    if (rv !== 8'h07) begin errors++; $display("FAIL busy_write_err: got %h required 07", rv); end
    wait_lasts(1, 500, 1'b0, "clamp");
    build_exp(300, 1'b0, 0);
    checks++;
    if (cap_data.size() != 140) begin errors++; $display("FAIL clamp_beats: got %0d required 140", cap_data.size()); end
    for (int i = 0; i < 140 && i < cap_data.size(); i++) begin
      checks++;
      if ({cap_data[i], cap_keep[i], cap_last[i]} !== {exp_data[i], exp_keep[i], exp_last[i]}) begin
        errors++;
        $display("FAIL clamp_beat%0d: got %h/%b/%b required %h/%b/%b", i, cap_data[i], cap_keep[i],
                 cap_last[i], exp_data[i], exp_keep[i], exp_last[i]);
      end
    end
    rd(8'd21, rv); checks++;
    if (rv !== 8'h80) begin errors++; $display("FAIL clamp_csum0: got %h required 80", rv); end
    rd(8'd22, rv); checks++;
    if (rv !== 8'h7F) begin errors++; $display("FAIL clamp_csum1: got %h required 7F", rv); end
    rd(8'd20, rv); checks++;
    if (rv !== 8'h06) begin errors++; $display("FAIL err_sticky: got %h required 06", rv); end
    wr(8'd19, 8'h09);
    rd(8'd20, rv); checks++;
    if (rv !== 8'h02) begin errors++; $display("FAIL err_clear: got %h required 02", rv); end
  endtask

  task automatic test_reset_midframe();
    int c = 0;
    wr(8'd19, 8'h00); wr(8'd12, 8'd4); wr(8'd13, 8'd0); wr(8'd19, 8'h02);
    clear_cap();
    wr(8'd19, 8'h03);
    while (cap_data.size() < 6 && c < 100) begin @(negedge clk); #1; c++; end
    checks++;
    if (cap_data.size() < 6) begin errors++; $display("FAIL mid_start: got %0d beats required 6", cap_data.size()); end
    reset = 1'b1;
    @(negedge clk); checks++;
    if ({tvalid, tlast, tkeep, tdata} !== 20'h0) begin
      errors++; $display("FAIL mid_reset_out: got %h required 0", {tvalid, tlast, tkeep, tdata});
    end
    @(negedge clk); reset = 1'b0;
    rd(8'd12, rv); checks++;
    if (rv !== 8'h00) begin errors++; $display("FAIL mid_reg12: got %h required 00", rv); end
    rd(8'd17, rv); checks++;
    if (rv !== 8'h00) begin errors++; $display("FAIL mid_reg17: got %h required 00", rv); end
    rd(8'd20, rv); checks++;
    if (rv !== 8'h00) begin errors++; $display("FAIL mid_status: got %h required 00", rv); end
    rd(8'd25, rv); checks++;
    if (rv !== 8'h00) begin errors++; $display("FAIL mid_frames_sent: got %h required 00", rv); end
    wr(8'd12, 8'd2); wr(8'd17, 8'd1);
    clear_cap();
    wr(8'd19, 8'h03);
    wait_lasts(1, 200, 1'b0, "restart");
    checks++;
    if (cap_data.size() != 13) begin errors++; $display("FAIL restart_beats: got %0d required 13", cap_data.size()); end
    if (cap_data.size() == 13) begin
      checks++;
      if (cap_data[0] !== 16'hAAAA) begin errors++; $display("FAIL restart_first: got %h required AAAA", cap_data[0]); end
      checks++;
      if ({cap_data[12], cap_keep[12], cap_last[12]} !== {16'h0001, 2'b11, 1'b1}) begin
        errors++; $display("FAIL restart_last: got %h/%b/%b required 0001/11/1", cap_data[12], cap_keep[12], cap_last[12]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_regs();
    test_basic_frame();
    test_odd_length();
    test_backpressure();
    test_pattern_gap();
    test_clamp_full();
    test_reset_midframe();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
